// File: rtl/addr_flag_bank_if.sv
// addr_flag_bank_if: DSP bus strobes, address/data and flag outputs of addr_flag_bank
interface addr_flag_bank_if #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 11
);
    logic              we_deb;
    logic              re_deb;
    logic [ADDR_W-1:0] ab_buf;
    logic [NUM_CH-1:0] db_in;
    logic [NUM_CH-1:0] signal_out;
    logic [NUM_CH-1:0] rd_data;
    logic              pulse_busy;
    modport master(output we_deb, re_deb, ab_buf, db_in, input signal_out, rd_data, pulse_busy);
    modport slave(input we_deb, re_deb, ab_buf, db_in, output signal_out, rd_data, pulse_busy);
endinterface

// File: rtl/addr_flag_bank.sv
// addr_flag_bank: address-decoded bank of set/clear flags with optional auto-clearing pulse mode
module addr_flag_bank #(
    parameter int                NUM_CH    = 8,
    parameter int                ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 11'h040,
    parameter int                PULSE_LEN = 16
) (
    input logic clkDspIn,
    input logic dsp_reset,
    addr_flag_bank_if.slave bus
);
    localparam int TW = $clog2(PULSE_LEN + 1);
    logic              we_q, re_q, we_ev, re_ev, cfg_hit, cfg_wr, busy;
    logic [ADDR_W-1:0] off;
    logic [NUM_CH-1:0] sig, sig_n, pulse_en;
    logic [TW-1:0]     tmr   [NUM_CH];
    logic [TW-1:0]     tmr_n [NUM_CH];
    // offset from the base wraps, so one unsigned compare covers the channel range
    assign off     = bus.ab_buf - BASE_ADDR;
    assign cfg_hit = off == ADDR_W'(NUM_CH);
    assign we_ev   = we_q && !bus.we_deb;
    assign re_ev   = re_q && !bus.re_deb && !we_ev;
    assign cfg_wr  = we_ev && cfg_hit;
    always_comb begin
        sig_n = sig;
        busy  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            busy     = busy || (tmr[k] != '0);
            tmr_n[k] = (tmr[k] == '0) ? '0 : tmr[k] - TW'(1);
            sig_n[k] = (tmr[k] == TW'(1)) ? 1'b0 : sig[k];
            if (we_ev && off == ADDR_W'(k)) begin
                sig_n[k] = 1'b1;
                tmr_n[k] = pulse_en[k] ? TW'(PULSE_LEN) : '0;
            end else if (re_ev && off == ADDR_W'(k)) begin
                sig_n[k] = 1'b0;
                tmr_n[k] = '0;
            end else if (cfg_wr && pulse_en[k] && !bus.db_in[k]) begin
                // leaving pulse mode freezes the output as a latched flag
                sig_n[k] = sig[k];
                tmr_n[k] = '0;
            end
        end
    end
    always_ff @(posedge clkDspIn or negedge dsp_reset) begin
        if (!dsp_reset) begin
            we_q     <= 1'b1;
            re_q     <= 1'b1;
            sig      <= '0;
            pulse_en <= '0;
            tmr      <= '{default: '0};
        end else begin
            we_q     <= bus.we_deb;
            re_q     <= bus.re_deb;
            sig      <= sig_n;
            pulse_en <= cfg_wr ? bus.db_in : pulse_en;
            tmr      <= tmr_n;
        end
    end
    assign bus.signal_out = sig;
    assign bus.pulse_busy = busy;
    assign bus.rd_data    = cfg_hit ? pulse_en : (off < ADDR_W'(NUM_CH)) ? sig : '0;
endmodule

// File: tb/tb_addr_flag_bank.sv
// tb_addr_flag_bank: vector table, corner sequences and randomized run against an event-level model
module tb_addr_flag_bank;
    localparam int NCH = 8;
    localparam int PL  = 16;
    localparam int BA  = 'h40;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    addr_flag_bank_if #(.NUM_CH(NCH), .ADDR_W(11)) bus();
    addr_flag_bank #(.NUM_CH(NCH), .ADDR_W(11), .BASE_ADDR(11'h040), .PULSE_LEN(PL)) dut (
        .clkDspIn(clk),
        .dsp_reset(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [10:0] addr;
        logic [7:0]  db;
        logic [7:0]  sig;
        logic [7:0]  rd;
        logic        busy;
    } vec_t;
    vec_t tv[14];

    // reference: each channel keeps its level and the cycle at which its pulse expires
    int       cyc;
    bit [7:0] m_out;
    int       m_exp[NCH];
    bit [7:0] m_en;
    bit       m_weq, m_req;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [10:0] a, input logic [7:0] d);
        bus.we_deb = we;
        bus.re_deb = re;
        bus.ab_buf = a;
        bus.db_in  = d;
    endtask

    task automatic do_reset();
        drive(1, 1, 11'h000, 8'h00);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic void m_reset();
        cyc = 0;
        m_out = '0;
        m_en = '0;
        m_weq = 1;
        m_req = 1;
        for (int k = 0; k < NCH; k++) m_exp[k] = 0;
    endfunction

    function automatic void m_edge();
        bit wev, rev;
        int a;
        cyc++;
        wev = m_weq && !bus.we_deb;
        rev = m_req && !bus.re_deb && !wev;
        a = int'(bus.ab_buf) - BA;
        for (int k = 0; k < NCH; k++) begin
            if ((wev || rev) && a == k) begin
                m_out[k] = wev;
                m_exp[k] = (wev && m_en[k]) ? cyc + PL : 0;
            end else if (wev && a == NCH && m_en[k] && !bus.db_in[k]) begin
                m_exp[k] = 0;
            end else if (m_exp[k] != 0 && m_exp[k] == cyc) begin
                m_out[k] = 0;
                m_exp[k] = 0;
            end
        end
        if (wev && a == NCH) m_en = bus.db_in;
        m_weq = bus.we_deb;
        m_req = bus.re_deb;
    endfunction

    function automatic bit m_busy();
        for (int k = 0; k < NCH; k++) if (m_exp[k] > cyc) return 1;
        return 0;
    endfunction

    function automatic logic [7:0] m_rd();
        int a;
        a = int'(bus.ab_buf) - BA;
        return (a == NCH) ? m_en : (a >= 0 && a < NCH) ? m_out : 8'h00;
    endfunction

    initial begin
        int hi, bz, lo, run;
        bit first_hi;
        tv[0]  = '{1, 1, 11'h042, 8'h00, 8'h00, 8'h00, 0};
        tv[1]  = '{0, 1, 11'h042, 8'h00, 8'h04, 8'h04, 0};
        tv[2]  = '{0, 1, 11'h042, 8'h00, 8'h04, 8'h04, 0};
        tv[3]  = '{1, 1, 11'h042, 8'h00, 8'h04, 8'h04, 0};
        tv[4]  = '{1, 0, 11'h042, 8'h00, 8'h00, 8'h00, 0};
        tv[5]  = '{1, 1, 11'h043, 8'h00, 8'h00, 8'h00, 0};
        tv[6]  = '{0, 0, 11'h043, 8'h00, 8'h08, 8'h08, 0};
        tv[7]  = '{1, 1, 11'h049, 8'h00, 8'h08, 8'h00, 0};
        tv[8]  = '{0, 1, 11'h049, 8'hff, 8'h08, 8'h00, 0};
        tv[9]  = '{1, 1, 11'h048, 8'h00, 8'h08, 8'h00, 0};
        tv[10] = '{0, 1, 11'h048, 8'h0d, 8'h08, 8'h0d, 0};
        tv[11] = '{1, 1, 11'h048, 8'h00, 8'h08, 8'h0d, 0};
        tv[12] = '{1, 0, 11'h048, 8'h00, 8'h08, 8'h0d, 0};
        tv[13] = '{1, 1, 11'h010, 8'h00, 8'h08, 8'h00, 0};

        drive(1, 1, 11'h042, 8'h00);
        #2;
        chk("reset_sig", bus.signal_out, 8'h00);
        chk("reset_busy", bus.pulse_busy, 1'b0);
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].we, tv[i].re, tv[i].addr, tv[i].db);
            step();
            chk($sformatf("vec%0d_sig", i), bus.signal_out, tv[i].sig);
            chk($sformatf("vec%0d_rd", i), bus.rd_data, tv[i].rd);
            chk($sformatf("vec%0d_busy", i), bus.pulse_busy, tv[i].busy);
        end

        // single pulse with strobe held low for 40 clocks
        do_reset();
        drive(0, 1, 11'h048, 8'h01);
        step();
        drive(1, 1, 11'h040, 8'h00);
        step();
        drive(0, 1, 11'h040, 8'h00);
        hi = 0;
        bz = 0;
        first_hi = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0) first_hi = bus.signal_out[0];
            if (bus.signal_out[0]) hi++;
            if (bus.pulse_busy) bz++;
        end
        chk("pulse_first_edge", first_hi, 1'b1);
        chk("pulse_high_len", hi, PL);
        chk("pulse_busy_len", bz, PL);
        chk("pulse_end_low", bus.signal_out[0], 1'b0);

        // retrigger at timer=5
        drive(1, 1, 11'h040, 8'h00);
        step();
        drive(0, 1, 11'h040, 8'h00);
        step();
        drive(1, 1, 11'h040, 8'h00);
        lo = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (!bus.signal_out[0]) lo++;
        end
        drive(0, 1, 11'h040, 8'h00);
        step();
        drive(1, 1, 11'h040, 8'h00);
        run = bus.signal_out[0] ? 1 : 0;
        for (int i = 0; i < 30 && run > 0; i++) begin
            step();
            if (!bus.signal_out[0]) break;
            run++;
        end
        chk("retrig_no_glitch", lo, 0);
        chk("retrig_run", run, PL);

        // mode switch mid-pulse latches the output
        drive(0, 1, 11'h048, 8'h03);
        step();
        drive(1, 1, 11'h041, 8'h00);
        step();
        drive(0, 1, 11'h041, 8'h00);
        step();
        drive(1, 1, 11'h041, 8'h00);
        for (int i = 0; i < 8; i++) step();
        chk("mode_busy_before", bus.pulse_busy, 1'b1);
        drive(0, 1, 11'h048, 8'h00);
        step();
        drive(1, 1, 11'h048, 8'h00);
        chk("mode_busy_off", bus.pulse_busy, 1'b0);
        chk("mode_sig_held", bus.signal_out[1], 1'b1);
        for (int i = 0; i < 30; i++) step();
        chk("mode_sig_latched", bus.signal_out[1], 1'b1);
        chk("mode_busy_latched", bus.pulse_busy, 1'b0);

        // async reset between edges mid-pulse
        drive(0, 1, 11'h048, 8'h01);
        step();
        drive(1, 1, 11'h040, 8'h00);
        step();
        drive(0, 1, 11'h040, 8'h00);
        step();
        drive(1, 1, 11'h040, 8'h00);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_sig", bus.signal_out, 8'h00);
        chk("areset_busy", bus.pulse_busy, 1'b0);
        chk("areset_rd", bus.rd_data, 8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("areset_quiet_sig", bus.signal_out, 8'h00);
        chk("areset_quiet_busy", bus.pulse_busy, 1'b0);
        rst_n = 1'b0;
        drive(0, 1, 11'h042, 8'h00);
        #2;
        rst_n = 1'b1;
        step();
        chk("held_strobe_event", bus.signal_out, 8'h04);

        // randomized run against the model
        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                m_reset();
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
                  ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047)) : 11'(BA + $urandom_range(0, 10)),
                  8'($urandom));
            m_edge();
            step();
            chk("rand_sig", bus.signal_out, m_out);
            chk("rand_busy", bus.pulse_busy, m_busy());
            chk("rand_rd", bus.rd_data, m_rd());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addr_flag_bank.md
ADDR_FLAG_BANK -- requirements
Module: addr_flag_bank

Interface
REQ-001 Parameter NUM_CH, default 8, number of flag channels (1..16).
REQ-002 Parameter ADDR_W, default 11, width of decoded address bus.
REQ-003 Parameter BASE_ADDR, default 11'h040, address of channel 0. Channel k is at BASE_ADDR+k. The config register is at BASE_ADDR+NUM_CH.
REQ-004 Parameter PULSE_LEN, default 16, auto-clear length in clocks (>=1). Timer width = clog2(PULSE_LEN+1).
REQ-005 Port clkDspIn, input, 1, DSP bus clock; all state on rising edge.
REQ-006 Port dsp_reset, input, 1, reset, asynchronous, active-low; clock clkDspIn.
REQ-007 Port we_deb, input, 1, debounced write strobe, active-low.
REQ-008 Port re_deb, input, 1, debounced read strobe, active-low.
REQ-009 Port ab_buf, input, ADDR_W, buffered address bus.
REQ-010 Port db_in, input, NUM_CH, write data; used only at the config address.
REQ-011 Port signal_out, output, NUM_CH, flag outputs, registered.
REQ-012 Port rd_data, output, NUM_CH, readback, combinational from registers.
REQ-013 Port pulse_busy, output, 1, OR of all running channel timers, registered-derived.

Function
REQ-014 The block SHALL register we_deb and re_deb each clock into we_q and re_q (reset value 1).
REQ-015 A write event SHALL be we_q=1 and we_deb=0 at a rising edge; a read event SHALL be re_q=1 and re_deb=0. A strobe held low SHALL produce exactly one event.
REQ-016 ab_buf and db_in SHALL be sampled at the event edge. State SHALL update at that same edge, so latency is 0 clocks from the first edge sampling the strobe low.
REQ-017 If write and read events coincide, the write SHALL take effect and the read SHALL be ignored.
REQ-018 Write event at channel k: signal_out[k] SHALL become 1.
REQ-019 In that case, if pulse_en[k]=1, timer[k] SHALL load PULSE_LEN; otherwise timer[k] SHALL stay 0.
REQ-020 Read event at channel k: signal_out[k] SHALL become 0 and timer[k] SHALL become 0.
REQ-021 Each edge with timer[k]>0 and no event on channel k SHALL decrement timer[k]. When timer[k] goes 1->0, signal_out[k] SHALL become 0 at that edge, so the pulse is high for exactly PULSE_LEN clocks.
REQ-022 A write to channel k while its timer is running SHALL reload PULSE_LEN (retrigger); the output SHALL stay high with no glitch.
REQ-023 A write event at the config address SHALL load pulse_en <= db_in.
REQ-024 On a config write, any channel whose pulse_en bit goes 1->0 SHALL clear its timer and hold its output (becomes latched). A 0->1 change SHALL NOT start a timer on an already-set output.
REQ-025 A read event at the config address SHALL change no state.
REQ-026 Events at any other address SHALL change no state.
REQ-027 rd_data SHALL equal pulse_en when ab_buf = config address, signal_out when ab_buf is in the channel range, and 0 otherwise.
REQ-028 pulse_busy SHALL be 1 whenever any timer[k] is nonzero.
REQ-029 With no events, every register SHALL hold its value, apart from timer decrement.

Reset
REQ-030 dsp_reset=0 SHALL immediately force signal_out=0, all timers=0, pulse_en=0, we_q=1, re_q=1 and pulse_busy=0, independent of clock.
REQ-031 Reset asserted mid-pulse SHALL abort the pulse.
REQ-032 After release, a strobe already held low SHALL generate an event at the first edge, because we_q/re_q reset to 1.

Verification
REQ-033 Latch set/clear: write BASE_ADDR+2, then read BASE_ADDR+2 -> signal_out=8'h04 after the write edge, then 8'h00 after the read edge; rd_data=8'h04 between.
REQ-034 Pulse: config write db_in=8'h01, then write ch0 held low 40 clocks -> signal_out[0] high exactly 16 clocks; pulse_busy high for the same 16 clocks; single event only.
REQ-035 Retrigger: ch0 pulse mode, second write at timer=5 -> output high 16 more clocks from the second edge, with no low cycle.
REQ-036 Simultaneous we/re fall on ch3 (latched, currently 0) -> signal_out[3]=1; out-of-range address BASE_ADDR+9 write -> no change.
REQ-037 Mode switch: ch1 pulsing at timer=8, config write 8'h00 -> ch1 stays 1 indefinitely and pulse_busy=0.
REQ-038 Async reset asserted between clock edges mid-pulse -> all outputs 0 before the next edge; after release, no spurious event if the strobes are high.
